// File: rtl/mem_access_unit_if.sv
// Bundle of request, response and data-memory signals for mem_access_unit.
// slave: the unit itself; master: the pipeline/memory environment around it.
interface mem_access_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_load;
    logic        req_store;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;

    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic [4:0]  resp_rd;
    logic        done;
    logic        stall;
    logic        err;

    logic        dmem_read;
    logic        dmem_write;
    logic [31:0] dmem_address;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_mbe;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;

    modport slave (
        input  req_valid, req_load, req_store, req_funct3, req_addr, req_wdata, req_rd,
        input  dmem_rdata, dmem_resp,
        output req_ready, resp_valid, resp_rdata, resp_rd, done, stall, err,
        output dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_mbe
    );

    modport master (
        output req_valid, req_load, req_store, req_funct3, req_addr, req_wdata, req_rd,
        output dmem_rdata, dmem_resp,
        input  req_ready, resp_valid, resp_rdata, resp_rd, done, stall, err,
        input  dmem_read, dmem_write, dmem_address, dmem_wdata, dmem_mbe
    );
endinterface

// File: rtl/mem_access_unit.sv
// Memory-stage load/store unit: decodes one request, drives the data-memory
// handshake, positions store data/byte enables and extends load results.
module mem_access_unit #(
    parameter int unsigned MAX_WAIT = 64
) (
    input  logic             clk,
    input  logic             rst,
    mem_access_unit_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        FINISH
    } state_t;

    // Counter only needs to reach MAX_WAIT-1; the timeout fires on that BUSY cycle.
    localparam int unsigned CW = (MAX_WAIT < 2) ? 1 : $clog2(MAX_WAIT);
    localparam logic [CW-1:0] WAIT_LAST = (MAX_WAIT == 0) ? '0 : CW'(MAX_WAIT - 1);

    state_t        state;
    logic [CW-1:0] wait_cnt;

    logic          load_q;
    logic [2:0]    funct3_q;
    logic [1:0]    off_q;
    logic [4:0]    rd_q;

    logic          resp_valid;
    logic [31:0]   resp_rdata;
    logic [4:0]    resp_rd;
    logic          done;
    logic          err;
    logic          dmem_read;
    logic          dmem_write;
    logic [31:0]   dmem_address;
    logic [31:0]   dmem_wdata;
    logic [3:0]    dmem_mbe;

    logic          one_op;
    logic          both_ops;
    logic          f3_legal;
    logic          misaligned;
    logic          accept_ok;
    logic          accept_bad;
    logic [1:0]    off;
    logic [3:0]    mbe_n;
    logic [31:0]   wdata_n;

    // Align the returned word by byte offset, then sign/zero-extend per funct3.
    function automatic logic [31:0] extend(input logic [2:0] f3, input logic [1:0] o,
                                           input logic [31:0] word);
        logic [31:0] sh;
        sh = word >> {o, 3'b000};
        case (f3)
            3'b000:  extend = {{24{sh[7]}}, sh[7:0]};
            3'b100:  extend = {24'h000000, sh[7:0]};
            3'b001:  extend = {{16{sh[15]}}, sh[15:0]};
            3'b101:  extend = {16'h0000, sh[15:0]};
            default: extend = word;
        endcase
    endfunction

    // Request decode: legality, alignment, byte enables and shifted store data.
    always_comb begin
        off        = bus.req_addr[1:0];
        one_op     = bus.req_load ^ bus.req_store;
        both_ops   = bus.req_load & bus.req_store;
        f3_legal   = 1'b0;
        misaligned = 1'b0;
        mbe_n      = 4'b1111;
        wdata_n    = '0;

        if (bus.req_load) begin
            case (bus.req_funct3)
                3'b000, 3'b001, 3'b010, 3'b100, 3'b101: f3_legal = 1'b1;
                default:                                f3_legal = 1'b0;
            endcase
        end else if (bus.req_store) begin
            case (bus.req_funct3)
                3'b000, 3'b001, 3'b010: f3_legal = 1'b1;
                default:                f3_legal = 1'b0;
            endcase
        end

        case (bus.req_funct3[1:0])
            2'b01:   misaligned = off[0];
            2'b10:   misaligned = |off;
            default: misaligned = 1'b0;
        endcase

        if (bus.req_store) begin
            case (bus.req_funct3[1:0])
                2'b00: begin
                    mbe_n   = 4'b0001 << off;
                    wdata_n = bus.req_wdata << {off, 3'b000};
                end
                2'b01: begin
                    mbe_n   = 4'b0011 << off;
                    wdata_n = bus.req_wdata << {off, 3'b000};
                end
                default: begin
                    mbe_n   = 4'b1111;
                    wdata_n = bus.req_wdata;
                end
            endcase
        end

        accept_ok  = bus.req_valid & one_op & f3_legal & ~misaligned;
        accept_bad = bus.req_valid & (both_ops | (one_op & (~f3_legal | misaligned)));
    end

    // Transaction FSM with registered memory-side and completion outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            wait_cnt     <= '0;
            load_q       <= 1'b0;
            funct3_q     <= '0;
            off_q        <= '0;
            rd_q         <= '0;
            resp_valid   <= 1'b0;
            resp_rdata   <= '0;
            resp_rd      <= '0;
            done         <= 1'b0;
            err          <= 1'b0;
            dmem_read    <= 1'b0;
            dmem_write   <= 1'b0;
            dmem_address <= '0;
            dmem_wdata   <= '0;
            dmem_mbe     <= '0;
        end else begin
            done       <= 1'b0;
            resp_valid <= 1'b0;
            err        <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept_bad) begin
                        err <= 1'b1;
                    end else if (accept_ok) begin
                        dmem_address <= {bus.req_addr[31:2], 2'b00};
                        dmem_mbe     <= mbe_n;
                        dmem_wdata   <= wdata_n;
                        dmem_read    <= bus.req_load;
                        dmem_write   <= bus.req_store;
                        load_q       <= bus.req_load;
                        funct3_q     <= bus.req_funct3;
                        off_q        <= off;
                        rd_q         <= bus.req_rd;
                        wait_cnt     <= '0;
                        state        <= BUSY;
                    end
                end
                BUSY: begin
                    if (bus.dmem_resp) begin
                        dmem_read  <= 1'b0;
                        dmem_write <= 1'b0;
                        done       <= 1'b1;
                        if (load_q) begin
                            resp_valid <= 1'b1;
                            resp_rd    <= rd_q;
                            resp_rdata <= extend(funct3_q, off_q, bus.dmem_rdata);
                        end
                        state <= FINISH;
                    end else if ((MAX_WAIT != 0) && (wait_cnt == WAIT_LAST)) begin
                        dmem_read  <= 1'b0;
                        dmem_write <= 1'b0;
                        err        <= 1'b1;
                        state      <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready    = (state == IDLE);
    assign bus.stall        = (state != IDLE) |
                              (bus.req_valid & (bus.req_load | bus.req_store));
    assign bus.resp_valid   = resp_valid;
    assign bus.resp_rdata   = resp_rdata;
    assign bus.resp_rd      = resp_rd;
    assign bus.done         = done;
    assign bus.err          = err;
    assign bus.dmem_read    = dmem_read;
    assign bus.dmem_write   = dmem_write;
    assign bus.dmem_address = dmem_address;
    assign bus.dmem_wdata   = dmem_wdata;
    assign bus.dmem_mbe     = dmem_mbe;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: expected completions are queued when a
// request is driven and retired by a monitor when done/err/resp_valid fire.
module tb_mem_access_unit;

    logic clk;
    logic rst;

    mem_access_unit_if bus ();

    mem_access_unit #(.MAX_WAIT(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        done;
        logic        err;
        logic        rv;
        logic [31:0] rdata;
        logic [4:0]  rd;
    } exp_t;

    exp_t sb[$];
    int unsigned checks = 0;
    int unsigned errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic push(input logic d, input logic e, input logic rv,
                        input logic [31:0] rdata, input logic [4:0] rd);
        exp_t x;
        x.done = d; x.err = e; x.rv = rv; x.rdata = rdata; x.rd = rd;
        sb.push_back(x);
    endtask

    // Retire one expected completion for every completion-type pulse seen.
    always @(negedge clk) begin
        if (rst && (bus.done || bus.err || bus.resp_valid)) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_pulse", {29'd0, bus.done, bus.err, bus.resp_valid}, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("sb_kind", {29'd0, bus.done, bus.err, bus.resp_valid},
                      {29'd0, e.done, e.err, e.rv});
                if (e.rv) begin
                    check("sb_rdata", bus.resp_rdata, e.rdata);
                    check("sb_rd", {27'd0, bus.resp_rd}, {27'd0, e.rd});
                end
            end
        end
    end

    task automatic drive_req(input logic ld, input logic st, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [4:0] rd);
        @(negedge clk);
        bus.req_valid  = 1'b1;
        bus.req_load   = ld;
        bus.req_store  = st;
        bus.req_funct3 = f3;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        bus.req_rd     = rd;
        #1;
        check("accept_ready", {31'd0, bus.req_ready}, 32'd1);
        check("accept_stall", {31'd0, bus.stall}, {31'd0, ld | st});
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_load  = 1'b0;
        bus.req_store = 1'b0;
    endtask

    // Hold the response off for `hold` request cycles, checking bus stability.
    task automatic serve(input int unsigned hold, input logic is_wr, input logic [31:0] rdata,
                         input logic [31:0] addr, input logic [3:0] mbe,
                         input logic [31:0] wdata);
        for (int unsigned c = 0; c < hold; c++) begin
            @(negedge clk);
            check("busy_rw", {30'd0, bus.dmem_read, bus.dmem_write}, is_wr ? 32'd1 : 32'd2);
            check("busy_addr", bus.dmem_address, addr);
            check("busy_mbe", {28'd0, bus.dmem_mbe}, {28'd0, mbe});
            if (is_wr) check("busy_wdata", bus.dmem_wdata, wdata);
            check("busy_stall", {31'd0, bus.stall}, 32'd1);
            if (c == hold - 1) begin
                bus.dmem_rdata = rdata;
                bus.dmem_resp  = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        bus.dmem_resp  = 1'b0;
        bus.dmem_rdata = 32'h5A5A_5A5A;
        @(negedge clk);
        check("finish_done", {31'd0, bus.done}, 32'd1);
        check("finish_rw_low", {30'd0, bus.dmem_read, bus.dmem_write}, 32'd0);
        @(negedge clk);
        check("done_single", {31'd0, bus.done}, 32'd0);
        check("rv_single", {31'd0, bus.resp_valid}, 32'd0);
        check("idle_ready", {31'd0, bus.req_ready}, 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_load   = 1'b0;
        bus.req_store  = 1'b0;
        bus.req_funct3 = '0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.req_rd     = '0;
        bus.dmem_rdata = '0;
        bus.dmem_resp  = 1'b0;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rst_outs", {27'd0, bus.stall, bus.done, bus.err, bus.resp_valid, bus.dmem_read},
              32'd0);
        check("rst_rdata", bus.resp_rdata, 32'd0);
        check("rst_addr", bus.dmem_address, 32'd0);
        rst = 1'b1;

        // lb from 0x1003, response after 3 cycles.
        push(1'b1, 1'b0, 1'b1, 32'hFFFF_FF80, 5'd7);
        drive_req(1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0, 5'd7);
        serve(3, 1'b0, 32'h80FF_1234, 32'h0000_1000, 4'b1111, 32'h0);
        check("lb_hold_rdata", bus.resp_rdata, 32'hFFFF_FF80);

        // lhu from 0x2002, immediate response: done two cycles after accept.
        push(1'b1, 1'b0, 1'b1, 32'h0000_BEEF, 5'd3);
        drive_req(1'b1, 1'b0, 3'b101, 32'h0000_2002, 32'h0, 5'd3);
        serve(1, 1'b0, 32'hBEEF_0000, 32'h0000_2000, 4'b1111, 32'h0);

        // lh sign-extension, offset 0.
        push(1'b1, 1'b0, 1'b1, 32'hFFFF_8001, 5'd0);
        drive_req(1'b1, 1'b0, 3'b001, 32'h0000_2000, 32'h0, 5'd0);
        serve(2, 1'b0, 32'h1234_8001, 32'h0000_2000, 4'b1111, 32'h0);

        // lbu at offset 1.
        push(1'b1, 1'b0, 1'b1, 32'h0000_00C3, 5'd9);
        drive_req(1'b1, 1'b0, 3'b100, 32'h0000_2401, 32'h0, 5'd9);
        serve(1, 1'b0, 32'h11A2_C3D4, 32'h0000_2400, 4'b1111, 32'h0);

        // sh to 0x3002.
        push(1'b1, 1'b0, 1'b0, 32'h0, 5'd0);
        drive_req(1'b0, 1'b1, 3'b001, 32'h0000_3002, 32'h0000_ABCD, 5'd0);
        serve(2, 1'b1, 32'h0, 32'h0000_3000, 4'b1100, 32'hABCD_0000);

        // sb to 0x1001.
        push(1'b1, 1'b0, 1'b0, 32'h0, 5'd0);
        drive_req(1'b0, 1'b1, 3'b000, 32'h0000_1001, 32'h1234_5678, 5'd0);
        serve(1, 1'b1, 32'h0, 32'h0000_1000, 4'b0010, 32'h3456_7800);

        // Illegal / misaligned requests: err, no memory access, stays ready.
        push(1'b0, 1'b1, 1'b0, 32'h0, 5'd0);
        drive_req(1'b1, 1'b0, 3'b010, 32'h0000_4001, 32'h0, 5'd1);
        @(negedge clk);
        check("mis_err", {31'd0, bus.err}, 32'd1);
        check("mis_noread", {31'd0, bus.dmem_read}, 32'd0);
        check("mis_ready", {31'd0, bus.req_ready}, 32'd1);

        push(1'b0, 1'b1, 1'b0, 32'h0, 5'd0);
        drive_req(1'b1, 1'b0, 3'b011, 32'h0000_4000, 32'h0, 5'd1);
        @(negedge clk);
        check("f3_err", {31'd0, bus.err}, 32'd1);
        check("f3_noread", {31'd0, bus.dmem_read}, 32'd0);

        push(1'b0, 1'b1, 1'b0, 32'h0, 5'd0);
        drive_req(1'b1, 1'b1, 3'b010, 32'h0000_4000, 32'h0, 5'd1);
        @(negedge clk);
        check("both_err", {31'd0, bus.err}, 32'd1);
        check("both_norw", {30'd0, bus.dmem_read, bus.dmem_write}, 32'd0);
        check("both_ready", {31'd0, bus.req_ready}, 32'd1);

        // Neither load nor store: silently ignored, no stall.
        drive_req(1'b0, 1'b0, 3'b010, 32'h0000_4000, 32'h0, 5'd1);
        @(negedge clk);
        check("none_quiet", {29'd0, bus.err, bus.done, bus.dmem_read}, 32'd0);

        // Timeout with MAX_WAIT=4, then a store is accepted normally.
        push(1'b0, 1'b1, 1'b0, 32'h0, 5'd0);
        drive_req(1'b1, 1'b0, 3'b010, 32'h0000_7000, 32'h0, 5'd2);
        for (int unsigned c = 0; c < 4; c++) begin
            @(negedge clk);
            check("to_read_held", {31'd0, bus.dmem_read}, 32'd1);
        end
        @(negedge clk);
        check("to_read_low", {31'd0, bus.dmem_read}, 32'd0);
        check("to_err", {31'd0, bus.err}, 32'd1);
        check("to_nodone", {31'd0, bus.done}, 32'd0);
        check("to_ready", {31'd0, bus.req_ready}, 32'd1);
        push(1'b1, 1'b0, 1'b0, 32'h0, 5'd0);
        drive_req(1'b0, 1'b1, 3'b010, 32'h0000_6004, 32'hDEAD_BEEF, 5'd0);
        serve(2, 1'b1, 32'h0, 32'h0000_6004, 4'b1111, 32'hDEAD_BEEF);

        // Asynchronous reset while BUSY aborts without pulses.
        drive_req(1'b1, 1'b0, 3'b010, 32'h0000_5000, 32'h0, 5'd4);
        @(negedge clk);
        check("pre_rst_read", {31'd0, bus.dmem_read}, 32'd1);
        #2 rst = 1'b0;
        #1;
        check("arst_read", {31'd0, bus.dmem_read}, 32'd0);
        check("arst_ready", {31'd0, bus.req_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b1;
        for (int unsigned c = 0; c < 3; c++) begin
            @(negedge clk);
            check("post_rst_quiet", {28'd0, bus.done, bus.err, bus.resp_valid, bus.dmem_read},
                  32'd0);
            check("post_rst_ready", {31'd0, bus.req_ready}, 32'd1);
        end

        check("sb_empty", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Memory-stage consumer of the decoded control word.
- Takes one load/store request per transaction from the EX/MEM boundary and drives the data-memory read/write handshake.
- For stores, generates the byte-enable mask and shifts the write data into position.
- For loads, aligns and sign/zero-extends the returned word into a writeback value.
- Stalls the pipeline while a transaction is outstanding.

Parameters:
- MAX_WAIT, 64: cycles to wait for dmem_resp before abandoning the transaction. 0 disables the timeout.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- req_valid  in  1  memory op presented
- req_ready  out  1  unit can accept a request
- req_load  in  1  op is a load
- req_store  in  1  op is a store
- req_funct3  in  3  load/store width and sign (RV32I encoding)
- req_addr  in  32  byte address (ALU result)
- req_wdata  in  32  store data (rs2)
- req_rd  in  5  load destination register
- resp_valid  out  1  one-cycle pulse: load data ready
- resp_rdata  out  32  extended load result
- resp_rd  out  5  destination register for resp_rdata
- done  out  1  one-cycle pulse: transaction finished (load or store)
- stall  out  1  pipeline hold
- err  out  1  one-cycle pulse: illegal or misaligned request, or timeout
- dmem_read  out  1  memory read request
- dmem_write  out  1  memory write request
- dmem_address  out  32  word-aligned address ({req_addr[31:2],2'b00})
- dmem_wdata  out  32  shifted store data
- dmem_mbe  out  4  byte enables
- dmem_rdata  in  32  read data
- dmem_resp  in  1  memory response, valid for one cycle

Behaviour:
- Reset (asynchronous, any state): state=IDLE, wait counter=0; all outputs 0 except req_ready=1. A reset mid-transaction aborts it with no done/err pulse.
- States: IDLE, BUSY, FINISH.
- Derived outputs: req_ready = (state==IDLE). stall = (state!=IDLE) or (req_valid & (req_load|req_store) & state==IDLE), i.e. the stall is combinational in the accept cycle.
- Accept (IDLE, req_valid=1, exactly one of req_load/req_store=1):
  - Legal load funct3: 000 lb, 001 lh, 010 lw, 100 lbu, 101 lhu. Legal store funct3: 000 sb, 001 sh, 010 sw. All others are illegal.
  - Misaligned: halfword with addr[0]=1, or word with addr[1:0]!=0.
  - Illegal or misaligned: no memory access; err pulses next cycle; remain IDLE; no done.
  - Otherwise: register address, mbe, wdata, funct3, offset and rd; go to BUSY next cycle.
- Both req_load and req_store=1: illegal, err pulse, ignored. Neither set: ignored silently.
- BUSY:
  - dmem_read or dmem_write is asserted; it and all dmem_* outputs are held stable until dmem_resp is sampled high.
  - On dmem_resp: drop the request, capture dmem_rdata, go to FINISH.
  - The wait counter increments each BUSY cycle. If MAX_WAIT!=0 and the counter reaches MAX_WAIT without a response: drop the request, pulse err, return to IDLE, no done.
  - dmem_resp sampled outside BUSY is ignored.
- FINISH (one cycle):
  - done=1.
  - For loads, also resp_valid=1 and resp_rd=rd.
  - Next state IDLE. A new request is accepted the cycle after FINISH.
- Minimum latency: accept at cycle N, request visible N+1, dmem_resp at N+1, done/resp_valid at N+2.
- Store encoding, with off=addr[1:0]:
  - sw: mbe=1111, wdata unshifted.
  - sh: mbe=0011<<off, wdata = req_wdata<<(8*off).
  - sb: mbe=0001<<off, wdata = req_wdata<<(8*off).
  - Loads: mbe=1111.
- Load extraction, with off=addr[1:0]:
  - lw: the full word.
  - lh/lhu: halfword at bits [8*off+15 : 8*off], sign- or zero-extended.
  - lb/lbu: byte at bits [8*off+7 : 8*off], sign- or zero-extended.
- Outside FINISH: resp_rdata and resp_rd hold their last values; resp_valid=0.
- rd=0 loads complete normally; suppressing the writeback is the regfile's job.

Test Plan:
- lb from 0x1003, dmem_rdata=0x80FF_1234, resp after 3 cycles -> dmem_read held 3 cycles, address 0x1000, mbe 1111; resp_rdata=0xFFFF_FF80, resp_valid and done pulse once.
- lhu from 0x2002, dmem_rdata=0xBEEF_0000, immediate resp -> resp_rdata=0x0000_BEEF exactly 2 cycles after accept.
- sh to 0x3002 with wdata=0x0000_ABCD -> dmem_write=1, mbe=1100, dmem_wdata=0xABCD_0000; done pulses, resp_valid stays 0.
- lw to 0x4001 -> err pulse, dmem_read never asserted, unit stays ready; same for funct3=011 and for req_load & req_store both set.
- MAX_WAIT=4, load with no dmem_resp -> dmem_read high 4 cycles then low, err pulse, no done; a back-to-back sw is then accepted normally.
- rst driven low while BUSY, between clock edges -> dmem_read falls immediately; after release, req_ready=1 and no done/err pulses.
